// File: rtl/vx_alu_dp4a_iter_pkg.sv
// Shared types and helpers for the iterative DP4A processing element.
package vx_alu_dp4a_iter_pkg;

  localparam int unsigned DP4A_BYTES = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StResp
  } dp4a_state_e;

  // A byte becomes a 9-bit two's complement operand, so both signednesses share one multiplier.
  function automatic logic signed [8:0] dp4a_ext8(input logic [7:0] b, input logic is_signed);
    return {is_signed & b[7], b};
  endfunction

endpackage

// File: rtl/vx_dp4a_lane.sv
// One combinational DP4A lane: rs3 plus the sum of four byte products, modulo 2^32.
module vx_dp4a_lane
  import vx_alu_dp4a_iter_pkg::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rs3_i,
  input  logic        is_signed_i,
  output logic [31:0] res_o
);

  logic signed [17:0] prod;
  logic [31:0]        acc;

  always_comb begin
    acc  = rs3_i;
    prod = '0;
    for (int k = 0; k < DP4A_BYTES; k++) begin
      prod = dp4a_ext8(rs1_i[8*k +: 8], is_signed_i) * dp4a_ext8(rs2_i[8*k +: 8], is_signed_i);
      acc  = acc + {{14{prod[17]}}, prod};
    end
    res_o = acc;
  end

endmodule

// File: rtl/vx_alu_dp4a_iter.sv
// Iterative DP4A PE: latches one request, walks the lanes LANES_PER_CYCLE at a time, then commits.
module vx_alu_dp4a_iter
  import vx_alu_dp4a_iter_pkg::*;
#(
  parameter int unsigned NUM_LANES       = 4,
  parameter int unsigned LANES_PER_CYCLE = 1,
  parameter int unsigned XLEN            = 32,
  parameter int unsigned UUID_W          = 44,
  parameter int unsigned WID_W           = 2,
  parameter int unsigned RD_W            = 5,
  parameter int unsigned PID_W           = 1
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      exe_valid,
  output logic                      exe_ready,
  input  logic [UUID_W-1:0]         exe_uuid,
  input  logic [WID_W-1:0]          exe_wid,
  input  logic [NUM_LANES-1:0]      exe_tmask,
  input  logic [XLEN-1:0]           exe_pc,
  input  logic [RD_W-1:0]           exe_rd,
  input  logic                      exe_wb,
  input  logic                      exe_signed,
  input  logic [PID_W-1:0]          exe_pid,
  input  logic                      exe_sop,
  input  logic                      exe_eop,
  input  logic [NUM_LANES*XLEN-1:0] exe_rs1,
  input  logic [NUM_LANES*XLEN-1:0] exe_rs2,
  input  logic [NUM_LANES*XLEN-1:0] exe_rs3,

  output logic                      cmt_valid,
  input  logic                      cmt_ready,
  output logic [UUID_W-1:0]         cmt_uuid,
  output logic [WID_W-1:0]          cmt_wid,
  output logic [NUM_LANES-1:0]      cmt_tmask,
  output logic [XLEN-1:0]           cmt_pc,
  output logic [RD_W-1:0]           cmt_rd,
  output logic                      cmt_wb,
  output logic [PID_W-1:0]          cmt_pid,
  output logic                      cmt_sop,
  output logic                      cmt_eop,
  output logic [NUM_LANES*XLEN-1:0] cmt_data
);

  localparam int unsigned CNT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef struct packed {
    logic [UUID_W-1:0]    uuid;
    logic [WID_W-1:0]     wid;
    logic [NUM_LANES-1:0] tmask;
    logic [XLEN-1:0]      pc;
    logic [RD_W-1:0]      rd;
    logic                 wb;
    logic [PID_W-1:0]     pid;
    logic                 sop;
    logic                 eop;
  } dp4a_hdr_t;

  dp4a_state_e      state_q, state_d;
  logic [CNT_W-1:0] lane_cnt_q, lane_cnt_d;
  dp4a_hdr_t        hdr_q;
  logic             signed_q;
  logic [XLEN-1:0]  rs1_q [NUM_LANES];
  logic [XLEN-1:0]  rs2_q [NUM_LANES];
  logic [XLEN-1:0]  rs3_q [NUM_LANES];
  logic [XLEN-1:0]  res_q [NUM_LANES];

  logic             exe_fire;
  logic             last_grp;
  dp4a_hdr_t        exe_hdr;

  assign exe_ready = (state_q == StIdle);
  assign cmt_valid = (state_q == StResp);
  assign exe_fire  = exe_valid & exe_ready;
  assign last_grp  = (lane_cnt_q == CNT_W'(NUM_LANES - LANES_PER_CYCLE));

  assign exe_hdr = '{
    uuid:  exe_uuid,
    wid:   exe_wid,
    tmask: exe_tmask,
    pc:    exe_pc,
    rd:    exe_rd,
    wb:    exe_wb,
    pid:   exe_pid,
    sop:   exe_sop,
    eop:   exe_eop
  };

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (exe_valid) begin
          state_d    = StCompute;
          lane_cnt_d = '0;
        end
      end
      StCompute: begin
        lane_cnt_d = lane_cnt_q + CNT_W'(LANES_PER_CYCLE);
        if (last_grp) state_d = StResp;
      end
      StResp: begin
        if (cmt_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Lane group currently being evaluated; the index wraps only after the final group.
  logic [CNT_W-1:0] grp_idx [LANES_PER_CYCLE];
  logic [XLEN-1:0]  grp_res [LANES_PER_CYCLE];

  for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
    logic [31:0] lane_res;

    assign grp_idx[g] = lane_cnt_q + CNT_W'(g);

    vx_dp4a_lane u_lane (
      .rs1_i       (rs1_q[grp_idx[g]][31:0]),
      .rs2_i       (rs2_q[grp_idx[g]][31:0]),
      .rs3_i       (rs3_q[grp_idx[g]][31:0]),
      .is_signed_i (signed_q),
      .res_o       (lane_res)
    );

    assign grp_res[g] = !hdr_q.tmask[grp_idx[g]] ? '0 :
                        signed_q ? XLEN'($signed(lane_res)) : XLEN'(lane_res);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      lane_cnt_q <= '0;
      hdr_q      <= '0;
      signed_q   <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        rs1_q[l] <= '0;
        rs2_q[l] <= '0;
        rs3_q[l] <= '0;
        res_q[l] <= '0;
      end
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      if (exe_fire) begin
        hdr_q    <= exe_hdr;
        signed_q <= exe_signed;
        for (int l = 0; l < NUM_LANES; l++) begin
          rs1_q[l] <= exe_rs1[l*XLEN +: XLEN];
          rs2_q[l] <= exe_rs2[l*XLEN +: XLEN];
          rs3_q[l] <= exe_rs3[l*XLEN +: XLEN];
        end
      end
      if (state_q == StCompute) begin
        for (int g = 0; g < LANES_PER_CYCLE; g++) begin
          res_q[grp_idx[g]] <= grp_res[g];
        end
      end
    end
  end

  assign cmt_uuid  = hdr_q.uuid;
  assign cmt_wid   = hdr_q.wid;
  assign cmt_tmask = hdr_q.tmask;
  assign cmt_pc    = hdr_q.pc;
  assign cmt_rd    = hdr_q.rd;
  assign cmt_wb    = hdr_q.wb;
  assign cmt_pid   = hdr_q.pid;
  assign cmt_sop   = hdr_q.sop;
  assign cmt_eop   = hdr_q.eop;

  always_comb begin
    cmt_data = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      cmt_data[l*XLEN +: XLEN] = res_q[l];
    end
  end

endmodule

// File: tb/tb_vx_alu_dp4a_iter.sv
// Random and directed checks of the DP4A PE (one and two lanes per cycle) against a byte-level model.
module tb_vx_alu_dp4a_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_a, valid_b, ready_a, ready_b;
  logic [43:0]  exe_uuid;
  logic [1:0]   exe_wid;
  logic [3:0]   exe_tmask;
  logic [31:0]  exe_pc;
  logic [4:0]   exe_rd;
  logic         exe_wb, exe_signed, exe_sop, exe_eop;
  logic [0:0]   exe_pid;
  logic [127:0] exe_rs1, exe_rs2, exe_rs3;

  logic         a_exe_ready, a_cmt_valid, a_wb, a_sop, a_eop;
  logic [43:0]  a_uuid;
  logic [1:0]   a_wid;
  logic [3:0]   a_tmask;
  logic [31:0]  a_pc;
  logic [4:0]   a_rd;
  logic [0:0]   a_pid;
  logic [127:0] a_data;
  logic         b_exe_ready, b_cmt_valid, b_wb, b_sop, b_eop;
  logic [43:0]  b_uuid;
  logic [1:0]   b_wid;
  logic [3:0]   b_tmask;
  logic [31:0]  b_pc;
  logic [4:0]   b_rd;
  logic [0:0]   b_pid;
  logic [127:0] b_data;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0]  r1 [4];
  logic [31:0]  r2 [4];
  logic [31:0]  r3 [4];
  logic [127:0] exp_data;
  logic [43:0]  exp_uuid;
  logic [31:0]  exp_pc;
  logic [3:0]   exp_tmask;
  logic [4:0]   exp_rd;

  always #5 clk = ~clk;

  vx_alu_dp4a_iter #(.NUM_LANES(4), .LANES_PER_CYCLE(1)) dut_a (
    .clk(clk), .reset(reset),
    .exe_valid(valid_a), .exe_ready(a_exe_ready), .exe_uuid(exe_uuid), .exe_wid(exe_wid),
    .exe_tmask(exe_tmask), .exe_pc(exe_pc), .exe_rd(exe_rd), .exe_wb(exe_wb),
    .exe_signed(exe_signed), .exe_pid(exe_pid), .exe_sop(exe_sop), .exe_eop(exe_eop),
    .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .exe_rs3(exe_rs3),
    .cmt_valid(a_cmt_valid), .cmt_ready(ready_a), .cmt_uuid(a_uuid), .cmt_wid(a_wid),
    .cmt_tmask(a_tmask), .cmt_pc(a_pc), .cmt_rd(a_rd), .cmt_wb(a_wb), .cmt_pid(a_pid),
    .cmt_sop(a_sop), .cmt_eop(a_eop), .cmt_data(a_data)
  );

  vx_alu_dp4a_iter #(.NUM_LANES(4), .LANES_PER_CYCLE(2)) dut_b (
    .clk(clk), .reset(reset),
    .exe_valid(valid_b), .exe_ready(b_exe_ready), .exe_uuid(exe_uuid), .exe_wid(exe_wid),
    .exe_tmask(exe_tmask), .exe_pc(exe_pc), .exe_rd(exe_rd), .exe_wb(exe_wb),
    .exe_signed(exe_signed), .exe_pid(exe_pid), .exe_sop(exe_sop), .exe_eop(exe_eop),
    .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .exe_rs3(exe_rs3),
    .cmt_valid(b_cmt_valid), .cmt_ready(ready_b), .cmt_uuid(b_uuid), .cmt_wid(b_wid),
    .cmt_tmask(b_tmask), .cmt_pc(b_pc), .cmt_rd(b_rd), .cmt_wb(b_wb), .cmt_pid(b_pid),
    .cmt_sop(b_sop), .cmt_eop(b_eop), .cmt_data(b_data)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // rd = rs3 + sum of byte products, all in plain integer arithmetic, truncated to 32 bits.
  function automatic logic [31:0] dp4a_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input bit sgn);
    longint s;
    longint x, y;
    logic [7:0] ab, bb;
    s = longint'(c);
    for (int k = 0; k < 4; k++) begin
      ab = a[8*k +: 8];
      bb = b[8*k +: 8];
      if (sgn) begin
        x = longint'($signed(ab));
        y = longint'($signed(bb));
      end else begin
        x = longint'(ab);
        y = longint'(bb);
      end
      s = s + x * y;
    end
    return s[31:0];
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? b_exe_ready : a_exe_ready;
  endfunction

  function automatic logic cval(input bit sel);
    return sel ? b_cmt_valid : a_cmt_valid;
  endfunction

  task automatic fill(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    for (int l = 0; l < 4; l++) begin
      r1[l] = a;
      r2[l] = b;
      r3[l] = c;
    end
  endtask

  task automatic rand_ops();
    for (int l = 0; l < 4; l++) begin
      r1[l] = $urandom;
      r2[l] = $urandom;
      r3[l] = $urandom;
    end
  endtask

  task automatic scramble();
    exe_rs1  = {$urandom, $urandom, $urandom, $urandom};
    exe_rs2  = {$urandom, $urandom, $urandom, $urandom};
    exe_rs3  = {$urandom, $urandom, $urandom, $urandom};
    exe_uuid = {12'($urandom), 32'($urandom)};
    exe_pc   = $urandom;
    exe_tmask = 4'($urandom);
    exe_signed = 1'($urandom);
  endtask

  // Drive a request and return #1 after the edge at which it was accepted.
  task automatic issue(input bit sel, input logic [43:0] uuid, input logic [3:0] tm,
                       input bit sgn);
    int n;
    for (int l = 0; l < 4; l++) begin
      exp_data[l*32 +: 32] = tm[l] ? dp4a_ref(r1[l], r2[l], r3[l], sgn) : 32'h0;
      exe_rs1[l*32 +: 32]  = r1[l];
      exe_rs2[l*32 +: 32]  = r2[l];
      exe_rs3[l*32 +: 32]  = r3[l];
    end
    exp_uuid   = uuid;
    exp_tmask  = tm;
    exp_pc     = $urandom;
    exp_rd     = 5'($urandom);
    exe_uuid   = uuid;
    exe_tmask  = tm;
    exe_signed = sgn;
    exe_pc     = exp_pc;
    exe_rd     = exp_rd;
    exe_wid    = 2'($urandom);
    exe_wb     = 1'($urandom);
    exe_pid    = 1'($urandom);
    exe_sop    = 1'($urandom);
    exe_eop    = 1'($urandom);
    if (sel) valid_b = 1'b1;
    else valid_a = 1'b1;
    n = 0;
    while (!rdy(sel) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("exe_ready", 128'(rdy(sel)), 128'd1);
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    scramble();
  endtask

  // Called in the cycle after acceptance; checks latency, data, stall hold and release.
  task automatic collect(input bit sel, input int stall);
    int lat;
    lat = 1;
    while (!cval(sel) && lat < 50) begin
      check_eq("busy_ready", 128'(rdy(sel)), 128'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq(sel ? "latency_b" : "latency_a", 128'(lat), 128'(1 + (sel ? 2 : 4)));
    check_eq("data", sel ? b_data : a_data, exp_data);
    check_eq("uuid", 128'(sel ? b_uuid : a_uuid), 128'(exp_uuid));
    check_eq("pc", 128'(sel ? b_pc : a_pc), 128'(exp_pc));
    check_eq("tmask_rd", 128'({sel ? b_tmask : a_tmask, sel ? b_rd : a_rd}),
             128'({exp_tmask, exp_rd}));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_data", sel ? b_data : a_data, exp_data);
      check_eq("hold_hs", 128'({cval(sel), rdy(sel)}), 128'(2'b10));
    end
    if (sel) ready_b = 1'b1;
    else ready_a = 1'b1;
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    ready_b = 1'b0;
    check_eq("post_fire", 128'({cval(sel), rdy(sel)}), 128'(2'b01));
  endtask

  initial begin
    bit seen;
    reset   = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    scramble();
    exe_wid = '0; exe_rd = '0; exe_wb = 0; exe_pid = '0; exe_sop = 0; exe_eop = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_hs_a", 128'({a_cmt_valid, a_exe_ready}), 128'(2'b01));
    check_eq("rst_hs_b", 128'({b_cmt_valid, b_exe_ready}), 128'(2'b01));
    check_eq("rst_data", a_data, 128'h0);
    check_eq("rst_uuid", 128'(a_uuid), 128'h0);

    fill(32'h01020304, 32'h01010101, 32'd10);
    issue(0, 44'h1, 4'hF, 1);
    check_eq("basic_lane0", exp_data[31:0], 128'd20);
    collect(0, 0);

    fill(32'hFF000000, 32'h02000000, 32'd0);
    issue(0, 44'h2, 4'hF, 1);
    collect(0, 1);
    check_eq("sext_lane3", 128'(a_data[127:96]), 128'hFFFFFFFE);
    issue(0, 44'h3, 4'hF, 0);
    collect(0, 0);
    check_eq("zext_lane1", 128'(a_data[63:32]), 128'h1FE);

    fill(32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFFFF);
    issue(0, 44'h4, 4'b0101, 1);
    collect(0, 0);
    check_eq("wrap_mask", a_data, {32'h0, 32'h8000FC03, 32'h0, 32'h8000FC03});

    rand_ops();
    issue(0, 44'h77, 4'hF, 0);
    collect(0, 20);

    rand_ops();
    issue(0, 44'h99, 4'hF, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      if (a_cmt_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check_eq("rst_no_commit", 128'(seen), 128'd0);
    check_eq("rst_idle_ready", 128'(a_exe_ready), 128'd1);
    rand_ops();
    issue(0, 44'h5, 4'hF, 1);
    collect(0, 2);

    for (int t = 0; t < 8; t++) begin
      rand_ops();
      issue(1, 44'h100 + 44'(t), 4'($urandom), 1'($urandom));
      collect(1, $urandom_range(0, 3));
    end
    for (int t = 0; t < 4; t++) begin
      rand_ops();
      issue(0, 44'h200 + 44'(t), 4'($urandom), 1'($urandom));
      collect(0, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
